// File: rtl/sha256d_engine_if.sv
// sha256d_engine_if: start/busy/done handshake bundle for sha256d_engine.
//   start_i  : start request (sampled by the engine only while idle)
//   msg_i    : MSG_BITS-wide big-endian message, captured on an accepted start
//   busy_o   : engine busy
//   done_o   : one-cycle pulse when hash_o becomes valid
//   hash_o   : 256-bit digest, H0 in [255:224]
//   target_i : comparison target        (only with SHA256D_TARGET_CMP_EN)
//   hit_o    : byte-reversed hash <= target (only with SHA256D_TARGET_CMP_EN)
// master = requester side, slave = engine side.
interface sha256d_engine_if #(
  parameter int MSG_BITS = 640
);
  logic                start_i;
  logic [MSG_BITS-1:0] msg_i;
  logic                busy_o;
  logic                done_o;
  logic [255:0]        hash_o;
`ifdef SHA256D_TARGET_CMP_EN
  logic [255:0]        target_i;
  logic                hit_o;

  modport master (output start_i, msg_i, target_i, input busy_o, done_o, hash_o, hit_o);
  modport slave  (input start_i, msg_i, target_i, output busy_o, done_o, hash_o, hit_o);
`else
  modport master (output start_i, msg_i, input busy_o, done_o, hash_o);
  modport slave  (input start_i, msg_i, output busy_o, done_o, hash_o);
`endif
endinterface

// File: rtl/sha256d_engine.sv
// sha256d_engine: parametrised SHA256 / SHA256d sequencer around a sha256 core.
// The message is padded at elaboration time, streamed block by block into the
// core, the digest read back and (for PASSES=2) hashed a second time.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset (also resets the core)
//   bus   : sha256d_engine_if.slave (start/msg/busy/done/hash[/target/hit])
// Optional feature: define SHA256D_TARGET_CMP_EN to add target_i/hit_o and
// the registered byte-reversed-hash <= target comparator.
//
// sha256_core: one-round-per-cycle SHA256 compression core.
//   cmd_w_i/cmd_i : command strobe; 3'b010 first block, 3'b110 continuation,
//                   3'b001 read digest
//   text_i        : 16 block words after a write command, MSB word first
//   cmd_o[3]      : busy (loading or compressing)
//   text_o        : after a read, one idle cycle then H0..H7
module sha256_core (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_w_i,
  input  logic [2:0]  cmd_i,
  output logic [3:0]  cmd_o,
  input  logic [31:0] text_i,
  output logic [31:0] text_o
);
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic [31:0] h [8];
  logic [31:0] v [8];
  logic [31:0] vn [8];
  logic [31:0] w [16];
  logic [31:0] t1, t2, w_new;
  logic        loading, rounding;
  logic [3:0]  lcnt, rd_cnt;
  logic [5:0]  rnd;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // w[] is a sliding 16-word window of the schedule: w[k] holds W[t+k].
  always_comb begin
    t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
         ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[rnd] + w[0];
    t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
         ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9] +
            (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
    vn[0] = t1 + t2;
    vn[1] = v[0];
    vn[2] = v[1];
    vn[3] = v[2];
    vn[4] = v[3] + t1;
    vn[5] = v[4];
    vn[6] = v[5];
    vn[7] = v[6];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      loading  <= 1'b0;
      rounding <= 1'b0;
      lcnt     <= '0;
      rnd      <= '0;
      rd_cnt   <= '0;
    end else begin
      if (cmd_w_i && cmd_i[1]) begin
        loading <= 1'b1;
        lcnt    <= '0;
      end else if (loading) begin
        lcnt <= lcnt + 4'd1;
        if (lcnt == 4'd15) begin
          loading  <= 1'b0;
          rounding <= 1'b1;
          rnd      <= '0;
        end
      end else if (rounding) begin
        rnd <= rnd + 6'd1;
        if (rnd == 6'd63) rounding <= 1'b0;
      end
      // rd_cnt 1 is the idle cycle; 2..9 present H0..H7
      if (cmd_w_i && cmd_i == 3'b001) rd_cnt <= 4'd1;
      else if (rd_cnt == 4'd9)         rd_cnt <= '0;
      else if (rd_cnt != 4'd0)         rd_cnt <= rd_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_w_i && cmd_i[1] && !cmd_i[2])
      for (int i = 0; i < 8; i++) h[i] <= IV[i];
    if (loading) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= text_i;
      if (lcnt == 4'd15)
        for (int i = 0; i < 8; i++) v[i] <= h[i];
    end
    if (rounding) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
      for (int i = 0; i < 8; i++) v[i] <= vn[i];
      if (rnd == 6'd63)
        for (int i = 0; i < 8; i++) h[i] <= h[i] + vn[i];
    end
  end

  assign cmd_o  = {loading | rounding, 3'b000};
  assign text_o = (rd_cnt >= 4'd2) ? h[3'(rd_cnt - 4'd2)] : 32'd0;
endmodule

module sha256d_engine #(
  parameter int MSG_BITS = 640,
  parameter int PASSES   = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sha256d_engine_if.slave bus
);
  localparam int NUM_BLOCKS = (MSG_BITS + 65 + 511) / 512;
  localparam int BUF_W      = NUM_BLOCKS * 512;
  // MSG_BITS is a byte multiple, so this is always at least 7
  localparam int PAD_Z      = BUF_W - MSG_BITS - 65;
  localparam int BLK_W      = $clog2(NUM_BLOCKS + 1);

  typedef enum logic [2:0] {IDLE, WCMD, LOAD, WAIT, RCMD, RDLY, READ} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   msg_buf;
  logic [255:0]       digest_q, dig_next, hash_q;
  logic [BLK_W-1:0]   blk_q;
  logic               pass_q, busy_q, done_q;
  logic [3:0]         wcnt_q;
  logic [2:0]         rcnt_q;
  logic               cmd_w;
  logic [2:0]         cmd;
  logic [3:0]         core_cmd;
  logic [31:0]        core_text;
  logic               accept, last_blk, more_pass;

  function automatic logic [255:0] bswap(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  // start coinciding with the done pulse is deliberately dropped
  assign accept    = (state_q == IDLE) && bus.start_i && !done_q;
  assign last_blk  = pass_q ? (blk_q == '0) : (blk_q == BLK_W'(NUM_BLOCKS - 1));
  assign more_pass = (PASSES > 1) && !pass_q;
  assign dig_next  = {digest_q[223:0], core_text};

  sha256_core sha_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cmd_w_i(cmd_w),
    .cmd_i  (cmd),
    .cmd_o  (core_cmd),
    .text_i (msg_buf[BUF_W-1 -: 32]),
    .text_o (core_text)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cmd_w   = 1'b0;
    cmd     = 3'b000;
    case (state_q)
      IDLE: if (accept) state_d = WCMD;
      WCMD: begin
        cmd_w   = 1'b1;
        cmd     = (blk_q == '0) ? 3'b010 : 3'b110;
        state_d = LOAD;
      end
      LOAD: if (wcnt_q == 4'd15) state_d = last_blk ? RCMD : WAIT;
      WAIT: if (!core_cmd[3]) state_d = WCMD;
      RCMD: if (!core_cmd[3]) begin
        cmd_w   = 1'b1;
        cmd     = 3'b001;
        state_d = RDLY;
      end
      RDLY: state_d = READ;
      READ: if (rcnt_q == 3'd7) state_d = more_pass ? WCMD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hash_q <= '0;
      blk_q  <= '0;
      pass_q <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          busy_q <= 1'b1;
          blk_q  <= '0;
          pass_q <= 1'b0;
        end
        LOAD: begin
          wcnt_q <= wcnt_q + 4'd1;
          if (wcnt_q == 4'd15) blk_q <= blk_q + BLK_W'(1);
        end
        READ: begin
          rcnt_q <= rcnt_q + 3'd1;
          if (rcnt_q == 3'd7) begin
            if (more_pass) begin
              blk_q  <= '0;
              pass_q <= 1'b1;
            end else begin
              hash_q <= dig_next;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Message buffer is a shift register: the top word always feeds the core.
  always_ff @(posedge clk_i) begin
    if (accept)
      msg_buf <= {bus.msg_i, 1'b1, {PAD_Z{1'b0}}, 64'(MSG_BITS)};
    else if (state_q == LOAD)
      msg_buf <= {msg_buf[BUF_W-33:0], 32'd0};
    else if (state_q == READ && rcnt_q == 3'd7 && more_pass)
      msg_buf[BUF_W-1 -: 512] <= {dig_next, 8'h80, 184'd0, 64'h100};
    if (state_q == READ) digest_q <= dig_next;
  end

`ifdef SHA256D_TARGET_CMP_EN
  logic hit_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) hit_q <= 1'b0;
    else if (state_q == READ && rcnt_q == 3'd7 && !more_pass)
      hit_q <= (bswap(dig_next) <= bus.target_i);
  end
  assign bus.hit_o = hit_q;
`endif

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.hash_o = hash_q;
endmodule
